// File: rtl/rf_wb_arbiter_pkg.sv
// Shared types and constants for the register-file writeback arbiter.
package rf_wb_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned AW   = 5;

    localparam logic [AW-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic [AW-1:0]   addr;
        logic [XLEN-1:0] data;
    } wb_req_t;

    function automatic int unsigned ptr_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rf_wb_arbiter_rr_arbiter.sv
// Generic combinational round-robin arbiter: the search starts at ptr and wraps.
// The pointer register is owned by the instantiating block.
module rr_arbiter
    import rf_wb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 3,
    localparam int unsigned PW     = ptr_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PW-1:0]      ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [PW-1:0]      idx,
    output logic               found
);

    logic [PW-1:0] pos;

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        pos   = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            pos = PW'((32'(ptr) + k) % NUM_REQ);
            if (!found && req[pos]) begin
                found      = 1'b1;
                idx        = pos;
                grant[pos] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Round-robin arbiter sharing the register-file write port between NUM_REQ writeback sources.
// Define RF_WB_BYPASS_EN to forward the pending write onto the read-data outputs.
module rf_wb_arbiter
    import rf_wb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 3,
    parameter int unsigned XLEN    = rf_wb_pkg::XLEN,
    parameter int unsigned AW      = rf_wb_pkg::AW
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [NUM_REQ*AW-1:0]   req_addr,
    input  logic [NUM_REQ*XLEN-1:0] req_data,
    output logic [NUM_REQ-1:0]      req_ready,
    output logic                    rf_en,
    output logic [AW-1:0]           rf_wa,
    output logic [XLEN-1:0]         rf_wd,
    input  logic [AW-1:0]           byp_adr1,
    input  logic [AW-1:0]           byp_adr2,
    input  logic [XLEN-1:0]         rf_rs1_in,
    input  logic [XLEN-1:0]         rf_rs2_in,
    output logic [XLEN-1:0]         rs1_out,
    output logic [XLEN-1:0]         rs2_out
);

    localparam int unsigned PW = ptr_width(NUM_REQ);

    wb_req_t             reqs [NUM_REQ];
    logic [NUM_REQ-1:0]  null_req;
    logic [NUM_REQ-1:0]  elig;
    logic [NUM_REQ-1:0]  grant;
    logic [PW-1:0]       rr_ptr;
    logic [PW-1:0]       gidx;
    logic                found;

    always_comb begin
        null_req = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            reqs[k].addr = req_addr[k*AW +: AW];
            reqs[k].data = req_data[k*XLEN +: XLEN];
            null_req[k]  = req_valid[k] && (req_addr[k*AW +: AW] == REG_ZERO);
        end
    end

    // Writes to x0 are acknowledged immediately and never compete for the port.
    assign elig = req_valid & ~null_req;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req   (elig),
        .ptr   (rr_ptr),
        .grant (grant),
        .idx   (gidx),
        .found (found)
    );

    assign req_ready = rst ? '0 : (null_req | grant);

    always_ff @(posedge clk) begin
        if (rst) begin
            rf_en  <= 1'b0;
            rf_wa  <= '0;
            rf_wd  <= '0;
            rr_ptr <= '0;
        end else begin
            rf_en <= found;
            if (found) begin
                rf_wa  <= reqs[gidx].addr;
                rf_wd  <= reqs[gidx].data;
                rr_ptr <= (gidx == PW'(NUM_REQ - 1)) ? '0 : gidx + 1'b1;
            end
        end
    end

`ifdef RF_WB_BYPASS_EN
    assign rs1_out = (rf_en && rf_wa == byp_adr1 && byp_adr1 != REG_ZERO) ? rf_wd : rf_rs1_in;
    assign rs2_out = (rf_en && rf_wa == byp_adr2 && byp_adr2 != REG_ZERO) ? rf_wd : rf_rs2_in;
`else
    logic unused_byp;
    assign unused_byp = ^{byp_adr1, byp_adr2};
    assign rs1_out    = rf_rs1_in;
    assign rs2_out    = rf_rs2_in;
`endif

endmodule
